// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine timer: register map,
// reset constants and the byte-lane merge helper.
package wb_timer_pkg;

  // Number of word-address bits decoded (adr[4:2]).
  localparam int unsigned ADDR_DEC_W = 3;

  typedef enum logic [ADDR_DEC_W-1:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_PRESCALE    = 3'd4
  } reg_off_e;

  // mtimecmp resets to all-ones so the interrupt stays quiet until programmed.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes enabled by sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle (32-bit data, byte selects).
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, dat_m,
                  input  dat_s, ack, err, stall);
  modport slave  (input  cyc, stb, we, sel, adr, dat_m,
                  output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_timer_tick.sv
// Prescaler: emits a one-cycle tick every prescale+1 cycles.
module wb_timer_tick #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  restart,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Count up to prescale, tick and wrap; a restart zeroes the count without
  // ticking. ">=" keeps the period bounded even if prescale shrinks mid-count.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q >= prescale) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_timer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a Wishbone B4 pipelined slave.
//
// Handshake: the slave never stalls; a beat is accepted in every cycle where
// cyc & stb is high, and exactly one of ack/err follows in the next cycle
// (err for offsets 5-7). A response whose cycle has cyc low is suppressed,
// but the accepted write has already been applied. dat_s is non-zero only
// while ack is visible.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W   = 16,
  parameter int unsigned PRESCALE_RST = 0
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  wb,
  output logic irq_timer
);

  logic [63:0]           mtime_q,    mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           shadow_q,   shadow_d;
  logic [31:0]           dat_q,      dat_d;
  logic                  ack_q,      ack_d;
  logic                  err_q,      err_d;
  logic                  irq_q,      irq_d;

  logic                  beat;
  logic                  wr;
  logic                  rd;
  logic                  off_valid;
  logic [ADDR_DEC_W-1:0] off;
  logic                  restart;
  logic                  tick;
  logic                  unused_adr;

  assign beat      = wb.cyc & wb.stb;
  assign off       = wb.adr[4:2];
  assign off_valid = (off <= REG_PRESCALE);
  assign wr        = beat & wb.we;
  assign rd        = beat & ~wb.we;
  assign restart   = wr && (off == REG_PRESCALE);
  assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

  wb_timer_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale_q),
    .restart  (restart),
    .tick     (tick)
  );

  // Register writes, mtime increment, read-data capture and compare.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    prescale_d = prescale_q;
    shadow_d   = shadow_q;
    dat_d      = '0;
    ack_d      = beat & off_valid;
    err_d      = beat & ~off_valid;
    irq_d      = (mtime_q >= mtimecmp_q);

    // A bus write to either mtime half wins over a tick; the other half is
    // held as-is and no carry crosses that cycle. sel=0 writes touch nothing.
    if (wr && (off == REG_MTIME_LO) && (wb.sel != 4'b0000)) begin
      mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wb.dat_m, wb.sel)};
    end else if (wr && (off == REG_MTIME_HI) && (wb.sel != 4'b0000)) begin
      mtime_d = {byte_merge(mtime_q[63:32], wb.dat_m, wb.sel), mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr) begin
      case (off)
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], wb.dat_m, wb.sel);
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb.dat_m, wb.sel);
        REG_PRESCALE:    prescale_d = PRESCALE_W'(byte_merge(32'(prescale_q), wb.dat_m, wb.sel));
        default: ;
      endcase
    end

    // Reading the low word snapshots the high word so lo-then-hi is coherent.
    if (rd) begin
      case (off)
        REG_MTIME_LO: begin
          dat_d    = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        REG_MTIME_HI:    dat_d = shadow_q;
        REG_MTIMECMP_LO: dat_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: dat_d = mtimecmp_q[63:32];
        REG_PRESCALE:    dat_d = 32'(prescale_q);
        default:         dat_d = '0;
      endcase
    end
  end

  // State registers; reset also drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      prescale_q <= PRESCALE_W'(PRESCALE_RST);
      shadow_q   <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      prescale_q <= prescale_d;
      shadow_q   <= shadow_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.stall  = 1'b0;
  assign wb.ack    = ack_q & wb.cyc;
  assign wb.err    = err_q & wb.cyc;
  assign wb.dat_s  = wb.ack ? dat_q : 32'd0;
  assign irq_timer = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: directed bus sequences, expected responses queued at
// issue time and checked by an independent response monitor.
module tb_wb_timer;

  localparam logic [2:0] O_MLO  = 3'd0;
  localparam logic [2:0] O_MHI  = 3'd1;
  localparam logic [2:0] O_CLO  = 3'd2;
  localparam logic [2:0] O_CHI  = 3'd3;
  localparam logic [2:0] O_PRE  = 3'd4;
  localparam logic [2:0] O_BAD5 = 3'd5;
  localparam logic [2:0] O_BAD7 = 3'd7;

  logic clk;
  logic rst_n;
  logic irq_timer;

  wb_if wb_bus ();

  wb_timer #(.PRESCALE_W(16), .PRESCALE_RST(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb_bus),
    .irq_timer (irq_timer)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];   // {err, dat_s}
  logic [32:0] mon_exp;

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat; returns 1ns after the accepting edge with stb low, cyc high.
  task automatic beat(input logic we, input logic [2:0] off, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [31:0] exp_dat, input bit track);
    wb_bus.cyc   = 1'b1;
    wb_bus.stb   = 1'b1;
    wb_bus.we    = we;
    wb_bus.adr   = {27'd0, off, 2'b00};
    wb_bus.sel   = sel;
    wb_bus.dat_m = dat;
    if (track) exp_q.push_back({(off > 3'd4), exp_dat});
    @(posedge clk); #1;
    wb_bus.stb = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [3:0] sel, input logic [31:0] dat);
    beat(1'b1, off, sel, dat, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp_dat);
    beat(1'b0, off, 4'hF, 32'd0, exp_dat, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Let the last response show with cyc high, then release the bus.
  task automatic end_burst();
    @(posedge clk); #1;
    wb_bus.cyc = 1'b0;
    wb_bus.we  = 1'b0;
  endtask

  // Response monitor: every visible ack/err must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_bus.ack || wb_bus.err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: ack=%b err=%b dat_s=%h, none required",
                   wb_bus.ack, wb_bus.err, wb_bus.dat_s);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({wb_bus.ack, wb_bus.err} !== {~mon_exp[32], mon_exp[32]} ||
              wb_bus.dat_s !== mon_exp[31:0]) begin
            errors++;
            $display("FAIL resp: ack=%b err=%b dat_s=%h required ack=%b err=%b dat_s=%h",
                     wb_bus.ack, wb_bus.err, wb_bus.dat_s,
                     ~mon_exp[32], mon_exp[32], mon_exp[31:0]);
          end
        end
      end else begin
        checks++;
        if (wb_bus.dat_s !== 32'd0) begin
          errors++;
          $display("FAIL dat_idle: dat_s=%h required 0", wb_bus.dat_s);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst_n        = 1'b0;
    wb_bus.cyc   = 1'b0;
    wb_bus.stb   = 1'b0;
    wb_bus.we    = 1'b0;
    wb_bus.sel   = 4'h0;
    wb_bus.adr   = 32'd0;
    wb_bus.dat_m = 32'd0;
    idle(3);
    @(negedge clk);
    check("rst_ack",   {31'd0, wb_bus.ack},   32'd0);
    check("rst_err",   {31'd0, wb_bus.err},   32'd0);
    check("rst_dat",   wb_bus.dat_s,          32'd0);
    check("rst_stall", {31'd0, wb_bus.stall}, 32'd0);
    check("rst_irq",   {31'd0, irq_timer},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Byte-lane write into mtimecmp_lo from reset; sel=0 is acked and inert.
    wr(O_CLO, 4'b0010, 32'hAABB_CCDD);
    rd(O_CLO, 32'hFFFF_CCFF);
    wr(O_CHI, 4'b0000, 32'h1234_5678);
    rd(O_CHI, 32'hFFFF_FFFF);
    rd(O_PRE, 32'd0);
    end_burst();

    // Carry from lo into hi with PRESCALE=0.
    wr(O_PRE, 4'hF, 32'd0);
    wr(O_MHI, 4'hF, 32'd0);
    wr(O_MLO, 4'hF, 32'hFFFF_FFFE);
    idle(2);
    rd(O_MLO, 32'h0000_0000);
    rd(O_MHI, 32'h0000_0001);
    end_burst();

    // PRESCALE=3: five ticks land in the 20 cycles after the mtime write.
    wr(O_PRE, 4'hF, 32'd3);
    wr(O_MHI, 4'hF, 32'd0);
    wr(O_MLO, 4'hF, 32'd0);
    idle(19);
    rd(O_MLO, 32'd5);
    rd(O_MHI, 32'd0);
    rd(O_PRE, 32'd3);
    wr(O_PRE, 4'hF, 32'd0);
    end_burst();

    // Back-to-back reads 0,1,2,7 with the lo read straddling a carry.
    wr(O_MHI, 4'hF, 32'd7);
    wr(O_MLO, 4'hF, 32'hFFFF_FFFF);
    rd(O_MLO, 32'hFFFF_FFFF);
    rd(O_MHI, 32'd7);
    rd(O_CLO, 32'hFFFF_CCFF);
    rd(O_BAD7, 32'd0);
    wr(O_BAD5, 4'hF, 32'hDEAD_BEEF);
    rd(O_MHI, 32'd7);
    end_burst();

    // Interrupt rises one cycle after mtime reaches mtimecmp=10.
    wr(O_PRE, 4'hF, 32'd0);
    wr(O_MHI, 4'hF, 32'd0);
    wr(O_MLO, 4'hF, 32'd0);
    wr(O_CLO, 4'hF, 32'd10);
    wr(O_CHI, 4'hF, 32'd0);
    end_burst();
    idle(7);
    @(negedge clk);
    check("irq_before", {31'd0, irq_timer}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_rise", {31'd0, irq_timer}, 32'd1);
    @(posedge clk); #1;
    wr(O_CLO, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("irq_ack_cycle", {31'd0, irq_timer}, 32'd1);
    @(posedge clk); #1;
    wb_bus.cyc = 1'b0;
    @(negedge clk);
    check("irq_drop", {31'd0, irq_timer}, 32'd0);
    @(posedge clk); #1;

    // cyc dropped in the response cycle: no ack, write still lands.
    beat(1'b1, O_CHI, 4'hF, 32'h1234_5678, 32'd0, 1'b0);
    wb_bus.cyc = 1'b0;
    @(negedge clk);
    check("cycdrop_ack", {31'd0, wb_bus.ack}, 32'd0);
    check("cycdrop_err", {31'd0, wb_bus.err}, 32'd0);
    @(posedge clk); #1;
    rd(O_CHI, 32'h1234_5678);
    end_burst();

    // Force irq high, then reset in the response cycle of a beat.
    wr(O_CHI, 4'hF, 32'd0);
    wr(O_CLO, 4'hF, 32'd0);
    end_burst();
    @(negedge clk);
    check("irq_pre_rst", {31'd0, irq_timer}, 32'd1);
    @(posedge clk); #1;
    wr(O_PRE, 4'hF, 32'd5);
    rst_n      = 1'b0;
    wb_bus.cyc = 1'b0;
    wb_bus.we  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ack", {31'd0, wb_bus.ack}, 32'd0);
    check("midrst_err", {31'd0, wb_bus.err}, 32'd0);
    check("midrst_dat", wb_bus.dat_s,        32'd0);
    check("midrst_irq", {31'd0, irq_timer},  32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    check("post_rst_irq", {31'd0, irq_timer}, 32'd0);
    @(posedge clk); #1;
    rd(O_PRE, 32'd0);
    rd(O_CLO, 32'hFFFF_FFFF);
    rd(O_CHI, 32'hFFFF_FFFF);
    rd(O_MHI, 32'd0);
    end_burst();
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses missing, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
